mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory access controller in the M stage.
- Turns scalar or vector load/store requests from the M pipeline register into one or more word beats on a req/ack memory port.
- Drives `busy` into the hazard unit, which holds F/D/E/M while busy is high.
- Returns assembled scalar or vector read data to the M/W pipeline register.

Parameters:
- DATA_W, 32, width of one memory word and one vector lane.
- ADDR_W, 32, byte-address width.
- LANES, 4, vector elements per vector access (beats per vector access).
- TIMEOUT_CYC, 255, ack watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memreadM  in  1  M-stage instruction is a load.
- memwriteM  in  1  M-stage instruction is a store.
- vectorM  in  1  access is a vector access (LANES beats); 0 = scalar (1 beat).
- addrM  in  ADDR_W  base byte address (word aligned).
- wdataM  in  DATA_W  scalar store data.
- vwdataM  in  LANES*DATA_W  vector store data; lane i = bits [i*DATA_W +: DATA_W].
- rdataM  out  DATA_W  scalar load result.
- vrdataM  out  LANES*DATA_W  vector load result, same lane packing.
- busy  out  1  stall request to the hazard unit.
- err  out  1  sticky timeout flag (0 when MEM_TIMEOUT_EN is undefined).
- mem_req  out  1  beat request to memory.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  DATA_W  beat write data.
- mem_ack  in  1  memory accepted the beat (write) or returned data (read).
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdataM=0, vrdataM=0, busy=0, err=0.
  - Beat counter=0.
  - Reset mid-operation abandons the access; no further beats are issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busy = memreadM | memwriteM (combinational), so the M stage freezes in the same cycle the access appears.
  - If an access is present, next state is ACCESS. Latch we=memwriteM, total beats = vectorM ? LANES : 1, beat=0.
  - If memreadM and memwriteM are both high, the access is treated as a store.
- ACCESS:
  - busy=1 and mem_req=1.
  - mem_addr = addrM + 4*beat, mem_we = latched we.
  - mem_wdata = vectorM ? lane[beat] of vwdataM : wdataM.
  - M is stalled, so inputs are stable for the whole access.
  - Request signals are held stable until a cycle with mem_ack=1.
  - On a cycle with mem_ack=1:
    - Read: capture mem_rdata into lane[beat] of vrdataM; for a scalar read, into rdataM.
    - If beat == total-1, next state is DONE; otherwise beat+1 and the next beat is requested in the following cycle.
  - mem_req stays high across consecutive beats; a back-to-back ack gives 1 beat per cycle.
  - Minimum latency, from access seen in IDLE to DONE: scalar 2 cycles, vector LANES+1 cycles, with zero-wait memory.
- DONE:
  - busy=0 and mem_req=0.
  - rdataM/vrdataM hold the captured values; the pipeline advances on this edge.
  - Next state is always IDLE, so the completed instruction cannot retrigger.
  - Read outputs hold until the next read overwrites them.
  - Lanes not written by a scalar read are unchanged.
- mem_ack while mem_req=0 is ignored.
- Beat counter width is clog2(LANES)+1; it never wraps within an access.
- Store-only accesses never modify rdataM/vrdataM.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on each beat issue and on each ack, and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYC, the controller aborts the access: next state DONE, err set sticky until reset, and the remaining beats are skipped.
  - Read lanes not yet received retain their old values.
- MEM_TIMEOUT_EN undefined: no counter, err tied to 0, and the controller waits indefinitely for mem_ack.

Test Plan:
1. Reset during ACCESS (vector beat 2) -> same cycle: mem_req=0, busy=0, err=0, vrdataM=0; next cycle: state IDLE, no beat issued.
2. Scalar load, addrM=0x100, memory acks after 3 wait cycles with 0xDEADBEEF -> busy high for 5 cycles, mem_addr=0x100 stable, then DONE: rdataM=0xDEADBEEF, busy=0, mem_req=0.
3. Vector store, addrM=0x200, vwdataM lanes {0x11,0x22,0x33,0x44}, zero-wait ack -> beats at 0x200/0x204/0x208/0x20C carrying 0x11..0x44 with mem_we=1 on consecutive cycles; busy high for 5 cycles; rdataM/vrdataM unchanged.
4. Vector load with ack pattern 1,0,0,1,1,0,1 -> lanes captured only on ack cycles; mem_addr advances only after each ack; vrdataM = returned words in order.
5. Back-to-back: a scalar store followed immediately by a scalar load in M -> DONE has busy=0 for one cycle, then IDLE busy=1 for the load; exactly 2 mem beats total; no duplicate store.
6. MEM_TIMEOUT_EN, TIMEOUT_CYC=8, ack never arrives on beat 1 of a vector load -> abort after 8 wait cycles, err=1 sticky, busy drops in DONE, lane 0 valid, lanes 1-3 retain prior values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: turns scalar/vector loads and stores into req/ack word beats.
// Define MEM_TIMEOUT_EN to add the ack watchdog that aborts a stuck access and raises a sticky err.
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LANES       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memreadM,
    input  logic                    memwriteM,
    input  logic                    vectorM,
    input  logic [ADDR_W-1:0]       addrM,
    input  logic [DATA_W-1:0]       wdataM,
    input  logic [LANES*DATA_W-1:0] vwdataM,
    output logic [DATA_W-1:0]       rdataM,
    output logic [LANES*DATA_W-1:0] vrdataM,
    output logic                    busy,
    output logic                    err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata
);
    localparam int BW = $clog2(LANES) + 1;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q;
    logic [BW-1:0]           beat_q;
    logic [BW-1:0]           total_q;
    logic                    we_q;
    logic                    vec_q;
    logic                    memReq_q;
    logic                    memWe_q;
    logic [ADDR_W-1:0]       memAddr_q;
    logic [DATA_W-1:0]       memWdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [LANES*DATA_W-1:0] vrdata_q;

    logic [BW-1:0] beatNext;
    logic [IW-1:0] laneCur;
    logic [IW-1:0] laneNext;
    logic          lastBeat;
    logic          accessSeen;
    logic          timeoutHit;

    assign beatNext   = beat_q + BW'(1);
    assign laneCur    = beat_q[IW-1:0];
    assign laneNext   = beatNext[IW-1:0];
    assign lastBeat   = (beat_q == total_q - BW'(1));
    assign accessSeen = memreadM | memwriteM;

    // Stall must rise combinationally in the cycle the access first appears in M.
    assign busy = ~reset & (((state_q == IDLE) & accessSeen) | (state_q == ACCESS));

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign rdataM    = rdata_q;
    assign vrdataM   = vrdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wait_q;
    logic          err_q;

    assign timeoutHit = (wait_q == WW'(TIMEOUT_CYC - 1)) & ~mem_ack;
    assign err        = err_q;

    // Wait counter restarts on every ack (which is also when the next beat is issued).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != ACCESS || mem_ack) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_q + WW'(1);
            end
            if (state_q == ACCESS && timeoutHit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    // Request signals are registered and only change on entry to ACCESS or on an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            total_q    <= '0;
            we_q       <= 1'b0;
            vec_q      <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
            vrdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accessSeen) begin
                        state_q    <= ACCESS;
                        we_q       <= memwriteM;
                        vec_q      <= vectorM;
                        total_q    <= vectorM ? BW'(LANES) : BW'(1);
                        beat_q     <= '0;
                        memReq_q   <= 1'b1;
                        memWe_q    <= memwriteM;
                        memAddr_q  <= addrM;
                        memWdata_q <= vectorM ? vwdataM[DATA_W-1:0] : wdataM;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            vrdata_q[laneCur*DATA_W +: DATA_W] <= mem_rdata;
                            if (!vec_q) begin
                                rdata_q <= mem_rdata;
                            end
                        end
                        if (lastBeat) begin
                            state_q  <= DONE;
                            memReq_q <= 1'b0;
                            memWe_q  <= 1'b0;
                        end else begin
                            beat_q     <= beatNext;
                            memAddr_q  <= addrM + ADDR_W'({beatNext, 2'b00});
                            memWdata_q <= vec_q ? vwdataM[laneNext*DATA_W +: DATA_W] : wdataM;
                        end
                    end else if (timeoutHit) begin
                        state_q  <= DONE;
                        memReq_q <= 1'b0;
                        memWe_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
